// File: rtl/axi_to_mem_pkg.sv
// Shared definitions for the axi_to_mem write-response path.
//   resp_e         : AXI B response codes used by this block (OKAY, SLVERR).
//   RESP_W         : width of the resp field.
//   resp_from_err  : maps an accumulated burst error flag to a response code.
// B beat layout (MSB to LSB): id, resp, user.
package axi_to_mem_pkg;

  localparam int unsigned RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  function automatic resp_e resp_from_err(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_to_mem_b_gen_fifo.sv
// Small synchronous FIFO used twice by axi_to_mem_b_gen (ID queue, resp queue).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write request and data (ignored while full)
//   i_pop          : read request (ignored while empty)
//   o_data         : head entry (valid while !o_empty)
//   o_full/o_empty : occupancy flags, derived from a registered count
// A push and a pop in the same cycle are both honoured; a push while full is
// dropped even if a pop happens in that cycle.
module axi_to_mem_b_gen_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    o_full  = (r_count == CntW'(Depth));
    o_empty = (r_count == '0);
    w_push  = i_push & ~o_full;
    w_pop   = i_pop & ~o_empty;
    o_data  = r_mem[r_rptr];
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/axi_to_mem_b_gen.sv
// Write-response (B channel) generator on the memory side of axi_to_mem.
// Records the ID of each accepted AW burst, folds per-beat memory write errors
// into a burst status, and emits one in-order B beat per completed burst.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   aw_valid_i/aw_ready_o  : accepted-AW event; ready low while ID queue full
//   aw_id_i                : ID of that burst
//   beat_valid_i/_ready_o  : memory write-beat completion handshake
//   beat_last_i            : last beat of its burst
//   beat_err_i             : memory reported an error on this beat
//   valid_o/ready_i        : B channel handshake
//   data_o                 : {id, resp, user}, user always zero
module axi_to_mem_b_gen
  import axi_to_mem_pkg::*;
#(
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned UserWidth = 0,
  parameter int unsigned Depth     = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 aw_valid_i,
  output logic                                 aw_ready_o,
  input  logic [IdWidth-1:0]                   aw_id_i,
  input  logic                                 beat_valid_i,
  output logic                                 beat_ready_o,
  input  logic                                 beat_last_i,
  input  logic                                 beat_err_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [IdWidth+RESP_W+UserWidth-1:0]  data_o
);

  localparam int unsigned DataWidth = IdWidth + RESP_W + UserWidth;

  logic                 w_id_full;
  logic                 w_id_empty;
  logic [IdWidth-1:0]   w_id_head;
  logic                 w_resp_full;
  logic                 w_resp_empty;
  logic [RESP_W-1:0]    w_resp_head;
  logic [RESP_W-1:0]    w_resp_in;
  logic                 w_aw_push;
  logic                 w_beat_hs;
  logic                 w_resp_push;
  logic                 w_load;
  logic [DataWidth-1:0] w_b_next;
  logic                 r_err;
  logic                 r_valid;
  logic [DataWidth-1:0] r_data;

  always_comb begin
    aw_ready_o   = ~w_id_full;
    w_aw_push    = aw_valid_i & aw_ready_o;
    // Only a last beat needs a resp slot; other beats are never stalled.
    beat_ready_o = ~(beat_last_i & w_resp_full);
    w_beat_hs    = beat_valid_i & beat_ready_o;
    w_resp_push  = w_beat_hs & beat_last_i;
    w_resp_in    = resp_from_err(r_err | beat_err_i);
    w_load       = ~w_id_empty & ~w_resp_empty & (~r_valid | ready_i);
  end

  if (UserWidth > 0) begin : g_user
    always_comb w_b_next = {w_id_head, w_resp_head, {UserWidth{1'b0}}};
  end else begin : g_no_user
    always_comb w_b_next = {w_id_head, w_resp_head};
  end

  axi_to_mem_b_gen_fifo #(
    .Width (IdWidth),
    .Depth (Depth)
  ) u_id_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_aw_push),
    .i_data  (aw_id_i),
    .i_pop   (w_load),
    .o_data  (w_id_head),
    .o_full  (w_id_full),
    .o_empty (w_id_empty)
  );

  axi_to_mem_b_gen_fifo #(
    .Width (RESP_W),
    .Depth (Depth)
  ) u_resp_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_resp_push),
    .i_data  (w_resp_in),
    .i_pop   (w_load),
    .o_data  (w_resp_head),
    .o_full  (w_resp_full),
    .o_empty (w_resp_empty)
  );

  // Burst error accumulator; a stalled last beat leaves it untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_beat_hs) begin
      r_err <= beat_last_i ? 1'b0 : (r_err | beat_err_i);
    end
  end

  // Output register without fall-through; data only changes on a load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_b_next;
    end else if (r_valid & ready_i) begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    valid_o = r_valid;
    data_o  = r_data;
  end

  // More orphan completions than resp slots with no AW to pair them deadlocks.
  a_orphan_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(beat_valid_i & beat_last_i & w_resp_full & w_id_empty));

endmodule

// File: tb/tb_axi_to_mem_b_gen.sv
module tb_axi_to_mem_b_gen;

  localparam int unsigned IW    = 3;
  localparam int unsigned UW    = 0;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = IW + 2 + UW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          aw_valid_i = 1'b0;
  logic          aw_ready_o;
  logic [IW-1:0] aw_id_i = '0;
  logic          beat_valid_i = 1'b0;
  logic          beat_ready_o;
  logic          beat_last_i = 1'b0;
  logic          beat_err_i = 1'b0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [DW-1:0] data_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk_i = ~clk_i;

  axi_to_mem_b_gen #(
    .IdWidth   (IW),
    .UserWidth (UW),
    .Depth     (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .aw_valid_i   (aw_valid_i),
    .aw_ready_o   (aw_ready_o),
    .aw_id_i      (aw_id_i),
    .beat_valid_i (beat_valid_i),
    .beat_ready_o (beat_ready_o),
    .beat_last_i  (beat_last_i),
    .beat_err_i   (beat_err_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o)
  );

  function automatic logic [DW-1:0] bexp(input logic [IW-1:0] id, input logic [1:0] resp);
    return {id, resp};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    aw_valid_i   = 1'b0;
    beat_valid_i = 1'b0;
    beat_last_i  = 1'b0;
    beat_err_i   = 1'b0;
  endtask

  task automatic do_beats(input int unsigned n, input int unsigned errmask);
    for (int unsigned i = 0; i < n; i++) begin
      beat_valid_i = 1'b1;
      beat_last_i  = (i == n - 1);
      beat_err_i   = errmask[i];
      tick();
    end
    idle();
  endtask

  task automatic wait_valid(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    ready_i = 1'b0;
    repeat (3) tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (data_o !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_o); end
    rst_ni = 1'b1;
    tick();
    beat_last_i = 1'b1;
    #1;
    total++; if (aw_ready_o !== 1'b1) begin bad++; $display("FAIL reset_aw_ready got=%b exp=1", aw_ready_o); end
    total++; if (beat_ready_o !== 1'b1) begin bad++; $display("FAIL reset_beat_ready got=%b exp=1", beat_ready_o); end
    beat_last_i = 1'b0;
  endtask

  task automatic test_single_burst();
    ready_i    = 1'b1;
    aw_valid_i = 1'b1;
    aw_id_i    = 3'd3;
    tick();
    aw_valid_i = 1'b0;
    do_beats(4, 0);   // now in cycle N+1
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL single_n1_valid got=%b exp=0", valid_o); end
    tick();           // cycle N+2
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL single_n2_valid got=%b exp=1", valid_o); end
    total++; if (data_o !== bexp(3'd3, 2'b00)) begin bad++; $display("FAIL single_data got=%h exp=%h", data_o, bexp(3'd3, 2'b00)); end
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL single_n3_valid got=%b exp=0", valid_o); end
  endtask

  task automatic test_err_accum();
    bit ok;
    ready_i    = 1'b1;
    aw_valid_i = 1'b1;
    aw_id_i    = 3'd1;
    tick();
    aw_valid_i = 1'b0;
    do_beats(3, 32'b010);
    wait_valid(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL err_timeout got=no_valid exp=valid"); end
    total++; if (data_o !== bexp(3'd1, 2'b10)) begin bad++; $display("FAIL err_slverr got=%h exp=%h", data_o, bexp(3'd1, 2'b10)); end
    tick();
    aw_valid_i = 1'b1;
    aw_id_i    = 3'd2;
    tick();
    aw_valid_i = 1'b0;
    do_beats(2, 0);
    wait_valid(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL err2_timeout got=no_valid exp=valid"); end
    total++; if (data_o !== bexp(3'd2, 2'b00)) begin bad++; $display("FAIL err_cleared got=%h exp=%h", data_o, bexp(3'd2, 2'b00)); end
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL err_after_valid got=%b exp=0", valid_o); end
  endtask

  task automatic test_full_backpressure();
    logic [IW-1:0] ids [5];
    logic [1:0]    resps [4];
    ids[0] = 3'd5; ids[1] = 3'd6; ids[2] = 3'd1; ids[3] = 3'd2; ids[4] = 3'd3;
    ready_i = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      aw_valid_i = 1'b1;
      aw_id_i    = ids[k];
      #1;
      total++; if (aw_ready_o !== (k < 4)) begin bad++; $display("FAIL full_aw_ready k=%0d got=%b exp=%b", k, aw_ready_o, (k < 4)); end
      tick();
    end
    aw_valid_i = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      int unsigned e;
      e = $urandom_range(0, 1);
      resps[k] = (e != 0) ? 2'b10 : 2'b00;
      do_beats(1, e);
    end
    for (int unsigned s = 0; s < 5; s++) begin
      total++; if (valid_o !== 1'b1 || data_o !== bexp(ids[0], resps[0])) begin
        bad++; $display("FAIL stall_stable s=%0d got=%b/%h exp=1/%h", s, valid_o, data_o, bexp(ids[0], resps[0]));
      end
      tick();
    end
    ready_i = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      total++; if (valid_o !== 1'b1 || data_o !== bexp(ids[k], resps[k])) begin
        bad++; $display("FAIL b2b_order k=%0d got=%b/%h exp=1/%h", k, valid_o, data_o, bexp(ids[k], resps[k]));
      end
      tick();
    end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", valid_o); end
    total++; if (aw_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_aw_ready got=%b exp=1", aw_ready_o); end
  endtask

  task automatic test_early_completion();
    int unsigned e;
    logic [1:0]  r;
    ready_i = 1'b1;
    e = $urandom_range(0, 1);
    r = (e != 0) ? 2'b10 : 2'b00;
    do_beats(2, e << 1);
    for (int unsigned s = 0; s < 3; s++) begin
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL early_no_id s=%0d got=%b exp=0", s, valid_o); end
      tick();
    end
    aw_valid_i = 1'b1;
    aw_id_i    = 3'd7;
    tick();          // cycle M+1
    aw_valid_i = 1'b0;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL early_m1 got=%b exp=0", valid_o); end
    tick();          // cycle M+2
    total++; if (valid_o !== 1'b1 || data_o !== bexp(3'd7, r)) begin
      bad++; $display("FAIL early_m2 got=%b/%h exp=1/%h", valid_o, data_o, bexp(3'd7, r));
    end
    tick();
  endtask

  task automatic test_reset_midburst();
    bit ok;
    ready_i    = 1'b0;
    aw_valid_i = 1'b1;
    aw_id_i    = 3'd4;
    tick();
    aw_valid_i = 1'b0;
    do_beats(1, 0);
    wait_valid(5, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_pre_timeout got=no_valid exp=valid"); end
    aw_valid_i   = 1'b1;
    aw_id_i      = 3'd6;
    beat_valid_i = 1'b1;
    beat_err_i   = 1'b1;
    tick();
    idle();
    #2;
    rst_ni = 1'b0;
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b exp=0", valid_o); end
    total++; if (data_o !== '0) begin bad++; $display("FAIL rst_async_data got=%h exp=0", data_o); end
    tick();
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    tick();
    total++; if (valid_o !== 1'b0 || aw_ready_o !== 1'b1) begin
      bad++; $display("FAIL rst_post got=%b/%b exp=0/1", valid_o, aw_ready_o);
    end
    aw_valid_i = 1'b1;
    aw_id_i    = 3'd5;
    tick();
    aw_valid_i = 1'b0;
    do_beats(2, 0);
    wait_valid(5, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_new_timeout got=no_valid exp=valid"); end
    total++; if (data_o !== bexp(3'd5, 2'b00)) begin bad++; $display("FAIL rst_new_burst got=%h exp=%h", data_o, bexp(3'd5, 2'b00)); end
    tick();
  endtask

  // Reference: two queues plus one output slot, advanced once per cycle.
  task automatic test_random();
    logic [IW-1:0] m_ids [$];
    logic [1:0]    m_resps [$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_err;
    int            m_diff;
    bit aw_hs, beat_hs, load, b_hs;
    m_valid = 1'b0; m_data = '0; m_err = 1'b0; m_diff = 0;
    idle();
    ready_i = 1'b0;
    rst_ni  = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    for (int unsigned c = 0; c < 600; c++) begin
      aw_valid_i   = ($urandom_range(0, 2) == 0);
      aw_id_i      = IW'($urandom);
      ready_i      = ($urandom_range(0, 9) < 6);
      beat_valid_i = ($urandom_range(0, 1) == 1);
      beat_last_i  = ($urandom_range(0, 2) == 0) && (m_diff < 2);
      beat_err_i   = ($urandom_range(0, 3) == 0);
      #1;
      total++; if (valid_o !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, valid_o, m_valid); end
      if (m_valid) begin
        total++; if (data_o !== m_data) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, data_o, m_data); end
      end
      total++; if (aw_ready_o !== (m_ids.size() < DEPTH)) begin
        bad++; $display("FAIL rnd_aw_ready c=%0d got=%b exp=%b", c, aw_ready_o, (m_ids.size() < DEPTH));
      end
      total++; if (beat_ready_o !== !(beat_last_i && m_resps.size() >= DEPTH)) begin
        bad++; $display("FAIL rnd_beat_ready c=%0d got=%b exp=%b", c, beat_ready_o, !(beat_last_i && m_resps.size() >= DEPTH));
      end
      aw_hs   = aw_valid_i && (m_ids.size() < DEPTH);
      beat_hs = beat_valid_i && (!beat_last_i || m_resps.size() < DEPTH);
      b_hs    = m_valid && ready_i;
      load    = (m_ids.size() > 0) && (m_resps.size() > 0) && (!m_valid || ready_i);
      if (load) begin
        m_data  = {m_ids.pop_front(), m_resps.pop_front()};
        m_valid = 1'b1;
      end else if (b_hs) begin
        m_valid = 1'b0;
      end
      if (aw_hs) begin
        m_ids.push_back(aw_id_i);
        m_diff--;
      end
      if (beat_hs) begin
        if (beat_last_i) begin
          m_resps.push_back((m_err || beat_err_i) ? 2'b10 : 2'b00);
          m_err = 1'b0;
          m_diff++;
        end else begin
          m_err = m_err || beat_err_i;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_single_burst();
    test_err_accum();
    test_full_backpressure();
    test_early_completion();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
